ysyx_22050019_div_issue: RTL and testbench



---
 rtl/ysyx_22050019_div_issue_pkg.sv | 41 ++++
 rtl/ysyx_22050019_div_issue_if.sv | 22 ++
 rtl/ysyx_22050019_div_issue.sv | 138 +++++++++++++
 tb/tb_ysyx_22050019_div_issue.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050019_div_issue_pkg.sv
// Shared constants for the divide issue stage: one-hot divider op types, funct3 codes,
// FSM state encoding and the funct3/word to divider-type decoder.
package ysyx_22050019_div_pkg;

   localparam logic [7:0] DivTypeDiv   = 8'h80;
   localparam logic [7:0] DivTypeDivu  = 8'h40;
   localparam logic [7:0] DivTypeDivuw = 8'h20;
   localparam logic [7:0] DivTypeDivw  = 8'h10;
   localparam logic [7:0] DivTypeRem   = 8'h08;
   localparam logic [7:0] DivTypeRemu  = 8'h04;
   localparam logic [7:0] DivTypeRemuw = 8'h02;
   localparam logic [7:0] DivTypeRemw  = 8'h01;

   localparam logic [2:0] Funct3Div  = 3'b100;
   localparam logic [2:0] Funct3Divu = 3'b101;
   localparam logic [2:0] Funct3Rem  = 3'b110;
   localparam logic [2:0] Funct3Remu = 3'b111;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDone,
      StDrain
   } div_state_e;

   // Returns 0 for any funct3 outside the M-extension divide group.
   function automatic logic [7:0] funct3_to_divtype(input logic [2:0] funct3, input logic word);
      logic [7:0] t;
      t = 8'h00;
      case (funct3)
         Funct3Div:  t = word ? DivTypeDivw  : DivTypeDiv;
         Funct3Divu: t = word ? DivTypeDivuw : DivTypeDivu;
         Funct3Rem:  t = word ? DivTypeRemw  : DivTypeRem;
         Funct3Remu: t = word ? DivTypeRemuw : DivTypeRemu;
         default:    t = 8'h00;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/ysyx_22050019_div_issue_if.sv
// Launch/result bus between the divide issue stage (master) and the divider (slave).
interface ysyx_22050019_div_issue_if #(
   parameter int unsigned XLEN = 64
);
   logic            div_valid;
   logic [7:0]      div_type;
   logic [XLEN-1:0] div_dividend;
   logic [XLEN-1:0] div_divisor;
   logic            div_result_ready;
   logic [XLEN-1:0] div_out;
   logic            div_result_ok;

   modport master (
      output div_valid, div_type, div_dividend, div_divisor, div_result_ready,
      input  div_out, div_result_ok
   );

   modport slave (
      input  div_valid, div_type, div_dividend, div_divisor, div_result_ready,
      output div_out, div_result_ok
   );
endinterface

// File: rtl/ysyx_22050019_div_issue.sv
// Divide issue/collect stage: accepts one request, launches the divider once, returns the result.
// Optional single-entry last-result cache enabled by YSYX_22050019_DIV_CACHE_EN.
module ysyx_22050019_div_issue
   import ysyx_22050019_div_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned TAG_W = 5
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [2:0]                         req_funct3,
   input  logic                               req_word,
   input  logic [XLEN-1:0]                    req_rs1,
   input  logic [XLEN-1:0]                    req_rs2,
   input  logic [TAG_W-1:0]                   req_rd,
   input  logic                               flush,
   ysyx_22050019_div_issue_if.master          div_bus,
   output logic                               resp_valid,
   input  logic                               resp_ready,
   output logic [XLEN-1:0]                    resp_data,
   output logic [TAG_W-1:0]                   resp_rd,
   output logic                               busy
);

   div_state_e       state_q;
   logic [7:0]       type_q;
   logic [XLEN-1:0]  rs1_q;
   logic [XLEN-1:0]  rs2_q;
   logic [TAG_W-1:0] rd_q;
   logic [XLEN-1:0]  data_q;

   logic [7:0]       req_type;
   logic             accept;
   logic             cache_hit;
   logic [XLEN-1:0]  cache_data;

   assign req_type = funct3_to_divtype(req_funct3, req_word);

   // A non-divide funct3 is refused outright so it can never reach the divider.
   assign req_ready = (state_q == StIdle) && (!req_valid || req_funct3[2]);
   assign accept    = req_valid && req_ready && !flush;

`ifdef YSYX_22050019_DIV_CACHE_EN
   logic            cache_valid_q;
   logic [7:0]      cache_type_q;
   logic [XLEN-1:0] cache_rs1_q;
   logic [XLEN-1:0] cache_rs2_q;
   logic [XLEN-1:0] cache_result_q;

   assign cache_hit  = cache_valid_q && (cache_type_q == req_type) &&
                       (cache_rs1_q == req_rs1) && (cache_rs2_q == req_rs2);
   assign cache_data = cache_result_q;

   // Filled only by completions that reach DONE; flush leaves the entry intact.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         cache_valid_q  <= 1'b0;
         cache_type_q   <= '0;
         cache_rs1_q    <= '0;
         cache_rs2_q    <= '0;
         cache_result_q <= '0;
      end else if (state_q == StWait && div_bus.div_result_ok && !flush) begin
         cache_valid_q  <= 1'b1;
         cache_type_q   <= type_q;
         cache_rs1_q    <= rs1_q;
         cache_rs2_q    <= rs2_q;
         cache_result_q <= div_bus.div_out;
      end
   end
`else
   assign cache_hit  = 1'b0;
   assign cache_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= StIdle;
         type_q  <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  type_q <= req_type;
                  rs1_q  <= req_rs1;
                  rs2_q  <= req_rs2;
                  rd_q   <= req_rd;
                  if (cache_hit) begin
                     data_q  <= cache_data;
                     state_q <= StDone;
                  end else begin
                     state_q <= StIssue;
                  end
               end
            end
            // The divider has already sampled the start pulse, so a flush must drain it.
            StIssue: state_q <= flush ? StDrain : StWait;
            StWait: begin
               if (div_bus.div_result_ok) begin
                  if (flush) begin
                     state_q <= StIdle;
                  end else begin
                     data_q  <= div_bus.div_out;
                     state_q <= StDone;
                  end
               end else if (flush) begin
                  state_q <= StDrain;
               end
            end
            StDone: begin
               if (flush || resp_ready) state_q <= StIdle;
            end
            StDrain: begin
               if (div_bus.div_result_ok) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign div_bus.div_valid        = (state_q == StIssue);
   assign div_bus.div_type         = (state_q == StIssue || state_q == StWait ||
                                      state_q == StDrain) ? type_q : 8'h00;
   assign div_bus.div_dividend     = rs1_q;
   assign div_bus.div_divisor      = rs2_q;
   assign div_bus.div_result_ready = (state_q == StWait) || (state_q == StDrain);

   assign resp_valid = (state_q == StDone);
   assign resp_data  = data_q;
   assign resp_rd    = rd_q;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_22050019_div_issue.sv
// Bench for ysyx_22050019_div_issue with a behavioural divider of fixed latency.
module tb_ysyx_22050019_div_issue;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned TAG_W = 5;
   localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [2:0]       req_funct3 = 3'b000;
   logic             req_word = 1'b0;
   logic [XLEN-1:0]  req_rs1 = '0;
   logic [XLEN-1:0]  req_rs2 = '0;
   logic [TAG_W-1:0] req_rd = '0;
   logic             flush = 1'b0;
   logic             resp_valid;
   logic             resp_ready = 1'b0;
   logic [XLEN-1:0]  resp_data;
   logic [TAG_W-1:0] resp_rd;
   logic             busy;

   int total = 0;
   int bad   = 0;

   ysyx_22050019_div_issue_if #(.XLEN(XLEN)) dbus ();

   ysyx_22050019_div_issue #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_word   (req_word),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .flush      (flush),
      .div_bus    (dbus),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Divider model: result_ok 1 cycle after start for exceptions, 34 for word ops, 66 otherwise.
   function automatic logic [63:0] ref_div(input logic [7:0] t, input logic [63:0] a,
                                           input logic [63:0] b);
      logic signed [63:0] sa, sb;
      logic [31:0] a32, b32, r32;
      logic signed [31:0] sa32, sb32;
      logic ovf, ovf32;
      sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      ovf   = (a == 64'h8000_0000_0000_0000) && (b == ALL1);
      ovf32 = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
      r32 = 32'h0;
      case (t)
         8'h80: return (b == 0) ? ALL1 : ovf ? a : 64'(sa / sb);
         8'h40: return (b == 0) ? ALL1 : a / b;
         8'h08: return (b == 0) ? a : ovf ? 64'h0 : 64'(sa % sb);
         8'h04: return (b == 0) ? a : a % b;
         8'h10: r32 = (b32 == 0) ? 32'hFFFF_FFFF : ovf32 ? a32 : 32'(sa32 / sb32);
         8'h20: r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
         8'h01: r32 = (b32 == 0) ? a32 : ovf32 ? 32'h0 : 32'(sa32 % sb32);
         8'h02: r32 = (b32 == 0) ? a32 : a32 % b32;
         default: r32 = 32'h0;
      endcase
      return {{32{r32[31]}}, r32};
   endfunction

   function automatic int ref_lat(input logic [7:0] t, input logic [63:0] a, input logic [63:0] b);
      logic word;
      word = (t & 8'h33) != 0;
      if (word) begin
         if (b[31:0] == 0 || (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
         return 34;
      end
      if (b == 0 || (a == 64'h8000_0000_0000_0000 && b == ALL1)) return 1;
      return 66;
   endfunction

   logic        m_pend;
   int          m_cnt;
   logic [63:0] m_res;

   always @(posedge clk) begin
      if (rst_n) begin
         m_pend <= 1'b0;
         m_cnt  <= 0;
         m_res  <= '0;
      end else if (dbus.div_valid) begin
         m_pend <= 1'b1;
         m_res  <= ref_div(dbus.div_type, dbus.div_dividend, dbus.div_divisor);
         m_cnt  <= ref_lat(dbus.div_type, dbus.div_dividend, dbus.div_divisor) - 1;
      end else if (m_pend) begin
         if (m_cnt != 0) m_cnt <= m_cnt - 1;
         else if (dbus.div_result_ready) m_pend <= 1'b0;
      end
   end

   assign dbus.div_result_ok = m_pend && (m_cnt == 0);
   assign dbus.div_out       = m_res;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_zero(input string nm);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_div_valid"}, 64'(dbus.div_valid), 64'd0);
      chk({nm, "_div_type"}, 64'(dbus.div_type), 64'd0);
      chk({nm, "_dividend"}, dbus.div_dividend, 64'd0);
      chk({nm, "_divisor"}, dbus.div_divisor, 64'd0);
      chk({nm, "_res_ready"}, 64'(dbus.div_result_ready), 64'd0);
      chk({nm, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({nm, "_resp_data"}, resp_data, 64'd0);
      chk({nm, "_resp_rd"}, 64'(resp_rd), 64'd0);
   endtask

   // One request; latency counted in cycles after the accept cycle.
   task automatic do_req(input string nm, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input logic [7:0] et, input logic [63:0] ed, input int elat,
                         input int edv, input int hold, input bit kill);
      int cyc, dv_cnt, dv_cyc;
      logic [7:0] dv_type;
      bit seen;
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = f3; req_word = w;
      req_rs1 = a; req_rs2 = b; req_rd = rd; resp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1; dv_cnt = 0; dv_cyc = 0; dv_type = 8'h00; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         if (dbus.div_valid) begin
            dv_cnt++; dv_cyc = cyc; dv_type = dbus.div_type;
         end
         if (resp_valid) seen = 1'b1;
         else begin
            @(posedge clk);
            cyc++;
         end
      end
      chk({nm, "_lat"}, seen ? 64'(cyc) : ALL1, 64'(elat));
      chk({nm, "_div_valid_cnt"}, 64'(dv_cnt), 64'(edv));
      if (edv != 0) begin
         chk({nm, "_div_valid_cyc"}, 64'(dv_cyc), 64'd1);
         chk({nm, "_div_type"}, 64'(dv_type), 64'(et));
      end
      chk({nm, "_data"}, resp_data, ed);
      chk({nm, "_rd"}, 64'(resp_rd), 64'(rd));
      chk({nm, "_type_done"}, 64'(dbus.div_type), 64'd0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); @(negedge clk);
         chk({nm, "_hold_valid"}, 64'(resp_valid), 64'd1);
         chk({nm, "_hold_data"}, resp_data, ed);
      end
      if (kill) flush = 1'b1;
      else resp_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; resp_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_busy_after"}, 64'(busy), 64'd0);
      chk({nm, "_valid_after"}, 64'(resp_valid), 64'd0);
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  rd;
      logic [7:0]  et;
      logic [63:0] ed;
      int          elat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit saw;
      vecs[0]  = '{3'b101, 1'b0, 64'd100, 64'd7, 5'd5, 8'h40, 64'd14, 68};
      vecs[1]  = '{3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 8'h01, ALL1, 36};
      vecs[2]  = '{3'b101, 1'b0, 64'd55, 64'd0, 5'd7, 8'h40, ALL1, 3};
      vecs[3]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 8'h80,
                   64'hFFFF_FFFF_FFFF_FFFA, 68};
      vecs[4]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 8'h08,
                   64'hFFFF_FFFF_FFFF_FFFE, 68};
      vecs[5]  = '{3'b111, 1'b0, 64'd100, 64'd7, 5'd10, 8'h04, 64'd2, 68};
      vecs[6]  = '{3'b100, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 5'd11, 8'h10, 64'd14, 36};
      vecs[7]  = '{3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12, 8'h20, ALL1, 36};
      vecs[8]  = '{3'b111, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 5'd13, 8'h02, 64'hF, 36};
      vecs[9]  = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, ALL1, 5'd14, 8'h80,
                   64'h8000_0000_0000_0000, 3};
      vecs[10] = '{3'b110, 1'b0, 64'd123, 64'd0, 5'd15, 8'h08, 64'd123, 3};
      vecs[11] = '{3'b110, 1'b1, 64'h0000_0000_8000_0000, ALL1, 5'd16, 8'h01, 64'd0, 3};

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk_idle_zero("reset");

      for (int i = 0; i < 12; i++) begin
         do_req($sformatf("v%0d", i), vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].rd,
                vecs[i].et, vecs[i].ed, vecs[i].elat, 1, (i == 2) ? 5 : 0, 1'b0);
      end

      // Flush while DONE drops the response without a handshake.
      do_req("kill_done", 3'b101, 1'b0, 64'd9, 64'd0, 5'd3, 8'h40, ALL1, 3, 1, 0, 1'b1);

      // Non-divide funct3 is refused; flush blocks an otherwise valid accept.
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = 3'b010; req_rs1 = 64'd4; req_rs2 = 64'd2;
      @(negedge clk);
      chk("bad_f3_ready", 64'(req_ready), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("bad_f3_busy", 64'(busy), 64'd0);
      chk("bad_f3_div_valid", 64'(dbus.div_valid), 64'd0);
      #1 req_funct3 = 3'b100; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_idle_busy", 64'(busy), 64'd0);

      // DIV 20/4 flushed at T+10 drains until the divider finishes at T+67.
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = 3'b100; req_word = 1'b0;
      req_rs1 = 64'd20; req_rs2 = 64'd4; req_rd = 5'd20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("drain_res_ready", 64'(dbus.div_result_ready), 64'd1);
      cyc = 11; saw = 1'b0;
      while (busy && cyc < 200) begin
         if (resp_valid) saw = 1'b1;
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      chk("drain_busy_end", 64'(cyc), 64'd68);
      chk("drain_no_resp", 64'(saw), 64'd0);
      do_req("after_drain", 3'b101, 1'b0, 64'd100, 64'd7, 5'd21, 8'h40, 64'd14, 68, 1, 0, 1'b0);

      // Reset at T+30 of a 64-bit op abandons it.
      @(posedge clk); #1;
      req_valid = 1'b1; req_funct3 = 3'b100; req_word = 1'b0;
      req_rs1 = 64'd1000; req_rs2 = 64'd3; req_rd = 5'd22;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (29) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_zero("mid_reset");
      saw = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (resp_valid || busy || dbus.div_result_ok) saw = 1'b1;
      end
      chk("reset_no_stale", 64'(saw), 64'd0);
      do_req("after_reset", 3'b111, 1'b0, 64'd100, 64'd7, 5'd23, 8'h04, 64'd2, 68, 1, 0, 1'b0);

`ifdef YSYX_22050019_DIV_CACHE_EN
      do_req("cache_fill", 3'b100, 1'b0, 64'd100, 64'd7, 5'd24, 8'h80, 64'd14, 68, 1, 0, 1'b0);
      do_req("cache_hit", 3'b100, 1'b0, 64'd100, 64'd7, 5'd25, 8'h80, 64'd14, 1, 0, 0, 1'b0);
      do_req("cache_miss", 3'b100, 1'b0, 64'd100, 64'd8, 5'd26, 8'h80, 64'd12, 68, 1, 0, 1'b0);
`else
      do_req("repeat_a", 3'b100, 1'b0, 64'd100, 64'd7, 5'd24, 8'h80, 64'd14, 68, 1, 0, 1'b0);
      do_req("repeat_b", 3'b100, 1'b0, 64'd100, 64'd7, 5'd25, 8'h80, 64'd14, 68, 1, 0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
